softmax_row_sched: RTL and testbench

Row scheduler for the N-lane `softmax` datapath (Q8.8 signed, 16-bit lanes). It accepts a stream of elements one per cycle and assembles them into an N-element row while tracking the running signed maximum. It then issues the packed row plus `max_x` to the datapath as a one-cycle `valid_in` pulse, buffers returned probability rows, and serialises them onto a ready/valid output stream. A credit counter guarantees that the datapath, which has no backpressure, can never overflow the result buffer.

---
 rtl/softmax_pkg.sv | 17 +
 rtl/softmax_row_fifo.sv | 55 +++++
 rtl/softmax_row_sched.sv | 138 +++++++++++++
 tb/tb_softmax_row_sched.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/softmax_pkg.sv
// Shared Q8.8 constants, scheduler FSM states and lane-slice helper for the softmax row path.
package softmax_pkg;

    localparam int unsigned DW   = 16;
    localparam int unsigned FRAC = 8;

    typedef enum logic [0:0] {
        StCollect,
        StIssue
    } state_e;

    // LSB position of lane k in a packed row of w-bit lanes.
    function automatic int unsigned lane_lsb(input int unsigned k, input int unsigned w);
        return k * w;
    endfunction

endpackage

// File: rtl/softmax_row_fifo.sv
// Row FIFO for returned probability rows; push and pop may coincide, even when full.
module softmax_row_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = 128
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wptr_q, rptr_q;
    logic [CW-1:0] cnt_q;
    logic          do_push, do_pop;

    assign full    = (cnt_q == CW'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign rdata   = mem_q[rptr_q];
    assign do_pop  = pop && !empty;
    // A full FIFO still accepts a write when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wptr_q] <= wdata;
                wptr_q        <= (wptr_q == AW'(DEPTH - 1)) ? '0 : wptr_q + AW'(1);
            end
            if (do_pop) begin
                rptr_q <= (rptr_q == AW'(DEPTH - 1)) ? '0 : rptr_q + AW'(1);
            end
            if (do_push && !do_pop) begin
                cnt_q <= cnt_q + CW'(1);
            end else if (do_pop && !do_push) begin
                cnt_q <= cnt_q - CW'(1);
            end
        end
    end

endmodule

// File: rtl/softmax_row_sched.sv
// Assembles N-element rows with a running signed max, issues them under credit control,
// buffers returned probability rows and serialises them onto a ready/valid stream.
module softmax_row_sched #(
    parameter int unsigned N     = 8,
    parameter int unsigned DW    = 16,
    parameter int unsigned DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [DW-1:0]   in_data,
    output logic            sm_en,
    output logic            sm_valid_in,
    output logic [N*DW-1:0] sm_x_flat,
    output logic [DW-1:0]   sm_max_x,
    input  logic            sm_valid_out,
    input  logic [N*DW-1:0] sm_prob_flat,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [DW-1:0]   out_data,
    output logic            out_last,
    output logic            err
);

    import softmax_pkg::*;

    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    state_e               state_q, state_d;
    logic [IW-1:0]        idx_q, idx_d, oidx_q, oidx_d;
    logic signed [DW-1:0] max_q, max_d;
    logic [N*DW-1:0]      row_q, row_d, x_q, x_d;
    logic [DW-1:0]        mx_q, mx_d;
    logic [CW-1:0]        credit_q, credit_d;
    logic                 en_q, err_q, err_d;
    logic                 in_hs, issue, out_hs, pop, full, empty;
    logic [N*DW-1:0]      head;

    softmax_row_fifo #(
        .DEPTH(DEPTH),
        .W    (N * DW)
    ) u_fifo (
        .clk  (clk),
        .rst  (rst),
        .push (sm_valid_out),
        .pop  (pop),
        .wdata(sm_prob_flat),
        .rdata(head),
        .full (full),
        .empty(empty)
    );

    always_comb begin
        in_ready    = en_q && (state_q == StCollect);
        in_hs       = in_valid && in_ready;
        issue       = (state_q == StIssue) && (credit_q != '0);
        out_valid   = !empty;
        out_hs      = out_valid && out_ready;
        out_last    = out_valid && (oidx_q == IW'(N - 1));
        pop         = out_hs && out_last;
        out_data    = head[lane_lsb(32'(oidx_q), DW) +: DW];
        sm_en       = en_q;
        sm_valid_in = issue;
        sm_x_flat   = x_q;
        sm_max_x    = mx_q;
        err         = err_q;
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        max_d   = max_q;
        row_d   = row_q;
        x_d     = x_q;
        mx_d    = mx_q;
        if (in_hs) begin
            row_d[lane_lsb(32'(idx_q), DW) +: DW] = in_data;
            if ((idx_q == '0) || ($signed(in_data) > max_q)) begin
                max_d = in_data;
            end
            if (idx_q == IW'(N - 1)) begin
                // Launch register loads on the final element so the row is ready in ISSUE.
                idx_d   = '0;
                state_d = StIssue;
                x_d     = row_d;
                mx_d    = max_d;
            end else begin
                idx_d = idx_q + IW'(1);
            end
        end
        if (issue) begin
            state_d = StCollect;
        end
    end

    always_comb begin
        credit_d = credit_q;
        if (issue && !pop) begin
            credit_d = credit_q - CW'(1);
        end else if (pop && !issue && (credit_q != CW'(DEPTH))) begin
            credit_d = credit_q + CW'(1);
        end
        oidx_d = oidx_q;
        if (out_hs) begin
            oidx_d = pop ? '0 : oidx_q + IW'(1);
        end
        err_d = err_q | (sm_valid_out && full && !pop);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= StCollect;
            idx_q    <= '0;
            oidx_q   <= '0;
            max_q    <= '0;
            row_q    <= '0;
            x_q      <= '0;
            mx_q     <= '0;
            credit_q <= CW'(DEPTH);
            en_q     <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            oidx_q   <= oidx_d;
            max_q    <= max_d;
            row_q    <= row_d;
            x_q      <= x_d;
            mx_q     <= mx_d;
            credit_q <= credit_d;
            en_q     <= 1'b1;
            err_q    <= err_d;
        end
    end

endmodule

// File: tb/tb_softmax_row_sched.sv
// Randomised and directed bench for softmax_row_sched against a queue-based row/credit model.
`timescale 1ns/1ps
module tb_softmax_row_sched;

    localparam int N     = 8;
    localparam int DW    = 16;
    localparam int DEPTH = 4;

    typedef logic [N*DW-1:0] row_t;
    typedef struct {
        int   due;
        row_t row;
    } echo_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic          sm_en;
    logic          sm_valid_in;
    row_t          sm_x_flat;
    logic [DW-1:0] sm_max_x;
    logic          sm_valid_out = 1'b0;
    row_t          sm_prob_flat = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic          err;

    softmax_row_sched #(
        .N    (N),
        .DW   (DW),
        .DEPTH(DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .sm_en       (sm_en),
        .sm_valid_in (sm_valid_in),
        .sm_x_flat   (sm_x_flat),
        .sm_max_x    (sm_max_x),
        .sm_valid_out(sm_valid_out),
        .sm_prob_flat(sm_prob_flat),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_last    (out_last),
        .err         (err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input row_t act, input row_t exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic row_t mkprob(input row_t x);
        return x ^ {N{16'h5A5A}};
    endfunction

    // Reference model state
    logic [DW-1:0] elems[$];
    logic [DW-1:0] in_q[$];
    row_t          rows[$];
    echo_t         echo_q[$];
    bit            pending = 0, merr = 0, men = 0, in_hs = 0, gap_en = 0;
    row_t          p_row, last_x;
    logic [DW-1:0] p_max, last_max;
    int            credits = DEPTH, oidx = 0, cyc = 0, out_mode = 0;
    int            issues = 0, accepted = 0, outs = 0, lasts = 0;

    always @(negedge clk) begin
        bit exp_ir, exp_vin, pop;
        cyc++;
        if (!rst) begin
            chk("rst_in_ready", row_t'(in_ready), '0);
            chk("rst_sm_en", row_t'(sm_en), '0);
            chk("rst_sm_valid_in", row_t'(sm_valid_in), '0);
            chk("rst_sm_x_flat", sm_x_flat, '0);
            chk("rst_sm_max_x", row_t'(sm_max_x), '0);
            chk("rst_out_valid", row_t'(out_valid), '0);
            chk("rst_out_data", row_t'(out_data), '0);
            chk("rst_out_last", row_t'(out_last), '0);
            chk("rst_err", row_t'(err), '0);
            elems.delete();
            rows.delete();
            echo_q.delete();
            pending = 0;
            credits = DEPTH;
            oidx    = 0;
            merr    = 0;
            men     = 0;
            in_hs   = 0;
        end else begin
            exp_ir  = men && !pending;
            exp_vin = pending && (credits > 0);
            chk("sm_en", row_t'(sm_en), row_t'(men));
            chk("in_ready", row_t'(in_ready), row_t'(exp_ir));
            chk("sm_valid_in", row_t'(sm_valid_in), row_t'(exp_vin));
            chk("out_valid", row_t'(out_valid), row_t'(rows.size() > 0));
            chk("err", row_t'(err), row_t'(merr));
            if (rows.size() > 0) begin
                chk("out_data", row_t'(out_data), row_t'(rows[0][oidx*DW +: DW]));
                chk("out_last", row_t'(out_last), row_t'(oidx == N - 1));
            end
            if (exp_vin) begin
                chk("sm_x_flat", sm_x_flat, p_row);
                chk("sm_max_x", row_t'(sm_max_x), row_t'(p_max));
                last_x   = p_row;
                last_max = p_max;
                issues++;
                echo_q.push_back('{cyc + 5, mkprob(p_row)});
            end
            in_hs = in_valid && in_ready;
            if (in_valid && exp_ir) begin
                elems.push_back(in_data);
                accepted++;
                if (elems.size() == N) begin
                    p_max = elems[0];
                    for (int k = 0; k < N; k++) begin
                        p_row[k*DW +: DW] = elems[k];
                        if ($signed(elems[k]) > $signed(p_max)) p_max = elems[k];
                    end
                    pending = 1;
                    elems.delete();
                end
            end
            if (exp_vin) begin
                pending = 0;
                credits--;
            end
            pop = 0;
            if ((rows.size() > 0) && out_ready) begin
                outs++;
                if (oidx == N - 1) begin
                    oidx = 0;
                    pop  = 1;
                    lasts++;
                end else begin
                    oidx++;
                end
            end
            if (sm_valid_out) begin
                if ((rows.size() < DEPTH) || pop) rows.push_back(sm_prob_flat);
                else merr = 1;
            end
            if (pop) begin
                void'(rows.pop_front());
                if (credits < DEPTH) credits++;
            end
            men = 1;
        end
    end

    // Input, output-ready and result-echo driver
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (!rst) begin
                in_valid     = 1'b0;
                sm_valid_out = 1'b0;
            end else begin
                if (in_hs) begin
                    void'(in_q.pop_front());
                    in_valid = 1'b0;
                end
                if (!in_valid && (in_q.size() > 0) && (!gap_en || ($urandom_range(3) != 0))) begin
                    in_valid = 1'b1;
                    in_data  = in_q[0];
                end
                case (out_mode)
                    0:       out_ready = 1'b0;
                    1:       out_ready = 1'b1;
                    default: out_ready = 1'($urandom_range(1));
                endcase
                if ((echo_q.size() > 0) && (echo_q[0].due <= cyc)) begin
                    sm_valid_out = 1'b1;
                    sm_prob_flat = echo_q[0].row;
                    void'(echo_q.pop_front());
                end else begin
                    sm_valid_out = 1'b0;
                end
            end
        end
    end

    task automatic wait_idle(input int budget, input string name);
        int n = 0;
        while (!((in_q.size() == 0) && !in_valid && (elems.size() == 0) && !pending &&
                 (echo_q.size() == 0) && (rows.size() == 0) && !sm_valid_out) && (n < budget)) begin
            @(posedge clk);
            n++;
        end
        chk(name, row_t'(n >= budget), '0);
    endtask

    task automatic push_row(input logic [DW-1:0] v[N]);
        for (int k = 0; k < N; k++) in_q.push_back(v[k]);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, finish required", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] v[N];
        int i0, o0, l0, a0, n;
        row_t exp_row;

        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        repeat (2) @(posedge clk);

        // Uniform row
        out_mode = 1;
        i0 = issues; o0 = outs; l0 = lasts;
        v = '{default: 16'h0050};
        push_row(v);
        wait_idle(200, "uniform_timeout");
        exp_row = {N{16'h0050}};
        chk("uniform_max", row_t'(last_max), row_t'(16'h0050));
        chk("uniform_row", last_x, exp_row);
        chk("uniform_issues", row_t'(issues - i0), row_t'(1));
        chk("uniform_outs", row_t'(outs - o0), row_t'(8));
        chk("uniform_lasts", row_t'(lasts - l0), row_t'(1));

        // Mixed row, lane ordering
        v = '{16'hFEE0, 16'h013B, 16'h0050, 16'h0352, 16'hFEC6, 16'hFFC4, 16'hFFDF, 16'h021C};
        push_row(v);
        wait_idle(200, "mixed_timeout");
        exp_row = {16'h021C, 16'hFFDF, 16'hFFC4, 16'hFEC6, 16'h0352, 16'h0050, 16'h013B, 16'hFEE0};
        chk("mixed_max", row_t'(last_max), row_t'(16'h0352));
        chk("mixed_lane3", row_t'(last_x[3*DW +: DW]), row_t'(16'h0352));
        chk("mixed_row", last_x, exp_row);

        // All-negative row with duplicate maximum
        v = '{16'hFFC4, 16'hFFDF, 16'hFFD0, 16'hFFC8, 16'hFFDF, 16'hFFCA, 16'hFFD5, 16'hFFC9};
        push_row(v);
        wait_idle(200, "neg_timeout");
        chk("neg_max", row_t'(last_max), row_t'(16'hFFDF));

        // Credit exhaustion
        out_mode = 0;
        i0 = issues; o0 = outs; l0 = lasts;
        for (int r = 0; r < 6; r++) begin
            for (int k = 0; k < N; k++) v[k] = 16'(r * 16 + k);
            push_row(v);
        end
        repeat (150) @(posedge clk);
        chk("credit_stall_issues", row_t'(issues - i0), row_t'(4));
        chk("credit_stall_in_ready", row_t'(in_ready), '0);
        chk("credit_stall_err", row_t'(err), '0);
        out_mode = 1;
        wait_idle(1000, "credit_timeout");
        chk("credit_issues", row_t'(issues - i0), row_t'(6));
        chk("credit_outs", row_t'(outs - o0), row_t'(48));
        chk("credit_lasts", row_t'(lasts - l0), row_t'(6));
        chk("credit_err", row_t'(err), '0);

        // Reset mid-row
        a0 = accepted;
        for (int k = 0; k < 5; k++) in_q.push_back(16'h7000);
        n = 0;
        while ((accepted < a0 + 5) && (n < 200)) begin
            @(posedge clk);
            n++;
        end
        chk("midrst_accept_timeout", row_t'(n >= 200), '0);
        in_q.delete();
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("async_in_ready", row_t'(in_ready), '0);
        chk("async_sm_en", row_t'(sm_en), '0);
        chk("async_sm_x_flat", sm_x_flat, '0);
        chk("async_sm_max_x", row_t'(sm_max_x), '0);
        chk("async_out_valid", row_t'(out_valid), '0);
        chk("async_err", row_t'(err), '0);
        @(posedge clk);
        #2 rst = 1'b1;
        v = '{16'h0003, 16'h0001, 16'h0008, 16'h0002, 16'h0005, 16'h0004, 16'h0007, 16'h0006};
        push_row(v);
        wait_idle(300, "midrst_timeout");
        exp_row = {16'h0006, 16'h0007, 16'h0004, 16'h0005, 16'h0002, 16'h0008, 16'h0001, 16'h0003};
        chk("midrst_max", row_t'(last_max), row_t'(16'h0008));
        chk("midrst_row", last_x, exp_row);

        // Random traffic
        gap_en   = 1;
        out_mode = 2;
        i0 = issues;
        for (int r = 0; r < 30; r++) begin
            for (int k = 0; k < N; k++) begin
                if ($urandom_range(1) == 1) v[k] = 16'($urandom);
                else v[k] = 16'($urandom_range(16)) - 16'd8;
            end
            push_row(v);
        end
        wait_idle(20000, "random_timeout");
        chk("random_issues", row_t'(issues - i0), row_t'(30));
        chk("random_err", row_t'(err), '0);

        // Spurious results overflow the buffer
        gap_en   = 0;
        out_mode = 0;
        l0 = lasts;
        repeat (2) @(posedge clk);
        for (int r = 0; r < 5; r++) begin
            echo_q.push_back('{cyc + 1 + r, {$urandom, $urandom, $urandom, $urandom}});
        end
        repeat (12) @(posedge clk);
        chk("spurious_err", row_t'(err), row_t'(1));
        out_mode = 1;
        wait_idle(300, "spurious_timeout");
        chk("spurious_lasts", row_t'(lasts - l0), row_t'(4));
        chk("spurious_err_sticky", row_t'(err), row_t'(1));

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
